// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and constants for the binary-to-BCD conversion scheduler.
// Includes the parallel add-3 correction used by each double-dabble step.
package bcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int             BIN_W     = 16;
    localparam int             DIGITS    = 4;
    localparam logic [15:0]    MAX_DEC   = 16'd9999;
    localparam int             SHIFT_CYC = 16;

    // Every digit is corrected from its pre-correction value, all in parallel.
    function automatic logic [4*DIGITS-1:0] dabble_correct(input logic [4*DIGITS-1:0] d);
        logic [4*DIGITS-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Requester-side bundle: level requests with packed binary values in,
// per-requester ack pulses and registered BCD/overflow results out.
interface bcd_conv_sched_if #(
    parameter int NREQ = 2
);
    import bcd_sched_pkg::*;

    logic [NREQ-1:0]       req;
    logic [NREQ*BIN_W-1:0] bin;
    logic [NREQ-1:0]       ack;
    logic [NREQ*BIN_W-1:0] bcd;
    logic [NREQ-1:0]       ovf;
    logic                  busy;

    modport master (output req, bin, input ack, bcd, ovf, busy);
    modport slave  (input req, bin, output ack, bcd, ovf, busy);

endinterface

// File: rtl/bcd_shift_engine.sv
// Sequential double-dabble datapath: one correct-then-shift step per clock.
// The BCD digits accumulate in sh[31:16] while the binary drains from sh[15:0].
module bcd_shift_engine
    import bcd_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [BIN_W-1:0] din,
    input  logic             step,
    output logic [BIN_W-1:0] dout,
    output logic             last
);

    logic [2*BIN_W-1:0] sh_reg;
    logic [3:0]         cnt_reg;
    logic [2*BIN_W-1:0] sh_next;

    assign sh_next = {dabble_correct(sh_reg[2*BIN_W-1:BIN_W]), sh_reg[BIN_W-1:0]} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg  <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            sh_reg  <= {{BIN_W{1'b0}}, din};
            cnt_reg <= '0;
        end else if (step) begin
            sh_reg  <= sh_next;
            cnt_reg <= cnt_reg + 4'd1;
        end
    end

    assign dout = sh_reg[2*BIN_W-1:BIN_W];
    // High while the step about to execute is the final one.
    assign last = (cnt_reg == 4'(SHIFT_CYC - 1));

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one double-dabble engine among NREQ requesters,
// holding a registered 4-digit BCD result and overflow flag per requester.
module bcd_conv_sched
    import bcd_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_conv_sched_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state_reg;
    logic [IW-1:0]    ptr_reg;
    logic [IW-1:0]    g_reg;
    logic [IW-1:0]    win;
    logic             ovf_tmp_reg;
    int               idx;
    logic [BIN_W-1:0] cur_bin;
    logic [BIN_W-1:0] clamped;
    logic [BIN_W-1:0] eng_dout;
    logic             eng_last;

    wire  [NREQ*BIN_W-1:0] bcd_flat;
    wire  [NREQ-1:0]       ovf_flat;
    wire  [NREQ-1:0]       ack_flat;

    assign cur_bin = bus.bin[int'(g_reg)*BIN_W +: BIN_W];
    assign clamped = (cur_bin > MAX_DEC) ? MAX_DEC : cur_bin;

    // Search downward so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        win = '0;
        idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req[idx]) begin
                win = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            g_reg       <= '0;
            ovf_tmp_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|bus.req) begin
                        g_reg     <= win;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    ovf_tmp_reg <= (cur_bin > MAX_DEC);
                    state_reg   <= SHIFT;
                end
                SHIFT: begin
                    if (eng_last) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    ptr_reg   <= (int'(g_reg) == NREQ - 1) ? '0 : g_reg + 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    bcd_shift_engine u_engine (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_reg == LOAD),
        .din   (clamped),
        .step  (state_reg == SHIFT),
        .dout  (eng_dout),
        .last  (eng_last)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_res
            logic [BIN_W-1:0] bcd_reg;
            logic             ovf_reg;
            logic             ack_reg;
            logic             hit;

            assign hit = (state_reg == DONE) && (g_reg == IW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bcd_reg <= '0;
                    ovf_reg <= 1'b0;
                    ack_reg <= 1'b0;
                end else begin
                    ack_reg <= hit;
                    if (hit) begin
                        bcd_reg <= eng_dout;
                        ovf_reg <= ovf_tmp_reg;
                    end
                end
            end

            assign bcd_flat[gi*BIN_W +: BIN_W] = bcd_reg;
            assign ovf_flat[gi]                = ovf_reg;
            assign ack_flat[gi]                = ack_reg;
        end
    endgenerate

    assign bus.bcd  = bcd_flat;
    assign bus.ovf  = ovf_flat;
    assign bus.ack  = ack_flat;
    assign bus.busy = (state_reg != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench: a single-requester instance for latency, value and reset
// scenarios, and a two-requester instance for round-robin ordering.
module tb_bcd_conv_sched;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    bcd_conv_sched_if #(.NREQ(1)) if1 ();
    bcd_conv_sched_if #(.NREQ(2)) if2 ();

    bcd_conv_sched #(.NREQ(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    bcd_conv_sched #(.NREQ(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raises req on dut1, waits (bounded) for ack, captures result and latency, drops req.
    task automatic run1(input logic [15:0] v, output logic [15:0] b, output logic o, output int lat);
        if1.req = 1'b1;
        if1.bin = v;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if1.ack[0]) begin
                lat = k;
                break;
            end
        end
        b = if1.bcd;
        o = if1.ovf[0];
        if1.req = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (if1.bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd1 got=%h exp=0000", if1.bcd); end
        checks++; if (if1.ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf1 got=%b exp=0", if1.ovf); end
        checks++; if (if1.ack !== 1'b0)     begin errors++; $display("FAIL reset_ack1 got=%b exp=0", if1.ack); end
        checks++; if (if1.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy1 got=%b exp=0", if1.busy); end
        checks++; if (if2.bcd !== 32'h0)    begin errors++; $display("FAIL reset_bcd2 got=%h exp=00000000", if2.bcd); end
        checks++; if (if2.ack !== 2'b00 || if2.busy !== 1'b0) begin
            errors++; $display("FAIL reset_ack_busy2 got=%b/%b exp=00/0", if2.ack, if2.busy);
        end
        $display("reset: bcd1=%h ovf1=%b busy1=%b bcd2=%h", if1.bcd, if1.ovf, if1.busy, if2.bcd);
    endtask

    task automatic test_single;
        logic [15:0] b;
        logic        o;
        int          lat;
        run1(16'd1234, b, o, lat);
        checks++; if (b !== 16'h1234) begin errors++; $display("FAIL single_bcd got=%h exp=1234", b); end
        checks++; if (o !== 1'b0)     begin errors++; $display("FAIL single_ovf got=%b exp=0", o); end
        checks++; if (lat !== 18)     begin errors++; $display("FAIL single_latency got=%0d exp=18", lat); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (if1.ack !== 1'b0)  begin errors++; $display("FAIL single_ack_pulse got=%b exp=0", if1.ack); end
        checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b exp=0", if1.busy); end
        $display("single: bin=1234 bcd=%h ovf=%b latency=%0d", b, o, lat);
    endtask

    task automatic test_busy_during;
        if1.req = 1'b1;
        if1.bin = 16'd3;
        @(posedge clk);
        @(negedge clk);
        checks++; if (if1.busy !== 1'b1) begin errors++; $display("FAIL busy_after_grant got=%b exp=1", if1.busy); end
        if1.req = 1'b0;
        for (int k = 0; k < 30 && !if1.ack[0]; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++; if (if1.bcd !== 16'h0003) begin errors++; $display("FAIL busy_run_bcd got=%h exp=0003", if1.bcd); end
        $display("busy: bin=3 bcd=%h", if1.bcd);
        @(negedge clk);
    endtask

    task automatic test_boundary;
        logic [15:0] vin [4]  = '{16'd0, 16'd9, 16'd10, 16'd9999};
        logic [15:0] vexp [4] = '{16'h0000, 16'h0009, 16'h0010, 16'h9999};
        logic [15:0] b;
        logic        o;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run1(vin[i], b, o, lat);
            @(negedge clk);
            checks++; if (b !== vexp[i]) begin errors++; $display("FAIL boundary_bcd[%0d] got=%h exp=%h", i, b, vexp[i]); end
            checks++; if (o !== 1'b0)    begin errors++; $display("FAIL boundary_ovf[%0d] got=%b exp=0", i, o); end
            $display("boundary: bin=%0d bcd=%h ovf=%b", vin[i], b, o);
        end
    endtask

    task automatic test_overflow;
        logic [15:0] vin [3]  = '{16'd10000, 16'd65535, 16'd42};
        logic [15:0] vexp [3] = '{16'h9999, 16'h9999, 16'h0042};
        logic        oexp [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] b;
        logic        o;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run1(vin[i], b, o, lat);
            @(negedge clk);
            checks++; if (b !== vexp[i]) begin errors++; $display("FAIL overflow_bcd[%0d] got=%h exp=%h", i, b, vexp[i]); end
            checks++; if (o !== oexp[i]) begin errors++; $display("FAIL overflow_ovf[%0d] got=%b exp=%b", i, o, oexp[i]); end
            $display("overflow: bin=%0d bcd=%h ovf=%b", vin[i], b, o);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] b;
        logic        o;
        int          lat;
        int          acks;
        // Prime ovf=1 so the reset clearing it is observable.
        run1(16'd20000, b, o, lat);
        @(negedge clk);
        if1.req = 1'b1;
        if1.bin = 16'd4321;
        for (int k = 0; k < 10; k++) @(posedge clk);
        #2;
        checks++; if (if1.busy !== 1'b1) begin errors++; $display("FAIL resetmid_busy_before got=%b exp=1", if1.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (if1.bcd !== 16'h0000) begin errors++; $display("FAIL resetmid_bcd got=%h exp=0000", if1.bcd); end
        checks++; if (if1.ovf !== 1'b0)     begin errors++; $display("FAIL resetmid_ovf got=%b exp=0", if1.ovf); end
        checks++; if (if1.busy !== 1'b0)    begin errors++; $display("FAIL resetmid_busy got=%b exp=0", if1.busy); end
        if1.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (if1.ack[0]) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL resetmid_no_ack got=%0d exp=0", acks); end
        run1(16'd4321, b, o, lat);
        @(negedge clk);
        checks++; if (b !== 16'h4321) begin errors++; $display("FAIL resetmid_rerun got=%h exp=4321", b); end
        $display("reset_mid: spurious_acks=%0d rerun bcd=%h", acks, b);
    endtask

    task automatic test_drop;
        int acks;
        int lat;
        if1.req = 1'b1;
        if1.bin = 16'd777;
        lat = -1;
        for (int k = 0; k < 5; k++) @(posedge clk);
        @(negedge clk);
        if1.req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if1.ack[0]) begin lat = k; break; end
        end
        checks++; if (lat < 0) begin errors++; $display("FAIL drop_ack got=none exp=pulse"); end
        checks++; if (if1.bcd !== 16'h0777) begin errors++; $display("FAIL drop_bcd got=%h exp=0777", if1.bcd); end
        acks = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (if1.ack[0] || if1.busy) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL drop_no_restart got=%0d exp=0", acks); end
        $display("drop: bcd=%h idle_violations=%0d", if1.bcd, acks);
    endtask

    task automatic test_two;
        int t0, t1;
        t0 = -1; t1 = -1;
        if2.bin = {16'd250, 16'd5};
        if2.req = 2'b11;
        for (int k = 0; k < 100 && (t0 < 0 || t1 < 0); k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if2.ack[0]) begin
                t0 = k; if2.req[0] = 1'b0;
                checks++; if (if2.bcd[15:0] !== 16'h0005) begin errors++; $display("FAIL two_bcd0 got=%h exp=0005", if2.bcd[15:0]); end
            end
            if (if2.ack[1]) begin
                t1 = k; if2.req[1] = 1'b0;
                checks++; if (if2.bcd[31:16] !== 16'h0250) begin errors++; $display("FAIL two_bcd1 got=%h exp=0250", if2.bcd[31:16]); end
            end
        end
        checks++; if (t0 !== 18) begin errors++; $display("FAIL two_ack0_time got=%0d exp=18", t0); end
        checks++; if (t1 !== 37) begin errors++; $display("FAIL two_ack1_time got=%0d exp=37", t1); end
        $display("two: ack0@%0d ack1@%0d bcd=%h", t0, t1, if2.bcd);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int order [4];
        int times [4];
        int n;
        int exp_ord;
        n = 0;
        // ptr is 0 after the previous scenario's grants 0 then 1.
        if2.req = 2'b11;
        for (int k = 0; k < 150 && n < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if2.ack !== 2'b00) begin
                order[n] = if2.ack[1] ? 1 : 0;
                times[n] = k;
                n++;
            end
        end
        if2.req = 2'b00;
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_ack_count got=%0d exp=4", n); end
        for (int i = 0; i < n; i++) begin
            exp_ord = i % 2;
            checks++; if (order[i] !== exp_ord) begin errors++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, order[i], exp_ord); end
            if (i > 0) begin
                checks++; if (times[i] - times[i-1] !== 19) begin
                    errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=19", i, times[i] - times[i-1]);
                end
            end
            $display("b2b: ack#%0d requester=%0d at=%0d", i, order[i], times[i]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        if1.req = '0;
        if1.bin = '0;
        if2.req = '0;
        if2.bin = '0;
        @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_single;
        test_busy_during;
        test_boundary;
        test_overflow;
        test_reset_mid;
        test_drop;
        test_two;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
